// File: rtl/demux1_2_stream.sv
// 1-to-2 stream demultiplexer: each output channel has a one-entry holding
// register with valid/ready handshaking and a wrapping count of accepted beats.
module demux1_2_stream #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  output logic          y1_valid,
  input  logic          y1_ready,
  output logic [DW-1:0] y1_data,
  output logic          y2_valid,
  input  logic          y2_ready,
  output logic [DW-1:0] y2_data,
  output logic [CW-1:0] y1_count,
  output logic [CW-1:0] y2_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e     st_q   [2];
  logic [DW-1:0] data_q [2];
  logic [CW-1:0] cnt_q  [2];

  logic [1:0] out_ready;
  logic [1:0] load;
  logic       accept;

  assign out_ready = {y2_ready, y1_ready};

  // Ready depends only on the selected channel's occupancy and consumer ready,
  // never on in_valid, so upstream may legally wait for ready before asserting valid.
  always_comb begin
    in_ready = rst_n & ((st_q[in_sel] == EMPTY) | out_ready[in_sel]);
    accept   = in_valid & in_ready;
    load     = {accept & in_sel, accept & ~in_sel};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]   <= EMPTY;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        unique case (st_q[i])
          EMPTY: begin
            if (load[i]) begin
              st_q[i]   <= FULL;
              data_q[i] <= in_data;
            end
          end
          FULL: begin
            if (load[i]) begin
              data_q[i] <= in_data;
            end else if (out_ready[i]) begin
              st_q[i] <= EMPTY;
            end
          end
          default: st_q[i] <= EMPTY;
        endcase
        if (load[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign y1_valid = (st_q[0] == FULL);
  assign y2_valid = (st_q[1] == FULL);
  assign y1_data  = data_q[0];
  assign y2_data  = data_q[1];
  assign y1_count = cnt_q[0];
  assign y2_count = cnt_q[1];

endmodule

// File: tb/tb_demux1_2_stream.sv
// Scoreboard bench for demux1_2_stream: the driver pushes accepted beats into
// per-channel queues; an independent monitor pops them as channels deliver.
module tb_demux1_2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sel;
  logic [7:0] in_data;
  logic       y1_valid, y1_ready, y2_valid, y2_ready;
  logic [7:0] y1_data, y2_data, y1_count, y2_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic       full [2];
  int         cnt  [2];

  demux1_2_stream #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data),
    .y2_valid(y2_valid), .y2_ready(y2_ready), .y2_data(y2_data),
    .y1_count(y1_count), .y2_count(y2_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides what the channels should hold.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic r1, input logic r2, output logic acc);
    logic rdy [2];
    logic ld;
    in_valid = v; in_sel = s; in_data = d; y1_ready = r1; y2_ready = r2;
    rdy[0] = r1; rdy[1] = r2;
    @(negedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      full[0] = 1'b0; full[1] = 1'b0;
      cnt[0] = 0; cnt[1] = 0;
      q1.delete(); q2.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!full[s] || rdy[s]));
      chk("y1_valid", 32'(y1_valid), 32'(full[0]));
      chk("y2_valid", 32'(y2_valid), 32'(full[1]));
      chk("y1_count", 32'(y1_count), 32'(cnt[0] % 256));
      chk("y2_count", 32'(y2_count), 32'(cnt[1] % 256));
      acc = v && in_ready;
      for (int c = 0; c < 2; c++) begin
        ld = acc && (int'(s) == c);
        full[c] = ld || (full[c] && !rdy[c]);
      end
      if (acc) begin
        if (s) q2.push_back(d); else q1.push_back(d);
        cnt[s]++;
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin : monitor
    logic       st1, st2;
    logic [7:0] h1, h2, e;
    st1 = 1'b0; st2 = 1'b0; h1 = '0; h2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st1 = 1'b0; st2 = 1'b0;
      end else begin
        if (st1) begin
          chk("y1_hold_valid", 32'(y1_valid), 32'd1);
          chk("y1_hold_data", 32'(y1_data), 32'(h1));
        end
        if (st2) begin
          chk("y2_hold_valid", 32'(y2_valid), 32'd1);
          chk("y2_hold_data", 32'(y2_data), 32'(h2));
        end
        if (y1_valid && y1_ready) begin
          if (q1.size() == 0) begin
            chk("y1_unexpected_beat", 32'(y1_data), 32'hFFFF_FFFF);
          end else begin
            e = q1.pop_front();
            chk("y1_data", 32'(y1_data), 32'(e));
          end
        end
        if (y2_valid && y2_ready) begin
          if (q2.size() == 0) begin
            chk("y2_unexpected_beat", 32'(y2_data), 32'hFFFF_FFFF);
          end else begin
            e = q2.pop_front();
            chk("y2_data", 32'(y2_data), 32'(e));
          end
        end
        st1 = y1_valid && !y1_ready; h1 = y1_data;
        st2 = y2_valid && !y2_ready; h2 = y2_data;
      end
    end
  end

  initial begin : driver
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    y1_ready = 1'b1; y2_ready = 1'b1;
    full[0] = 1'b0; full[1] = 1'b0; cnt[0] = 0; cnt[1] = 0;
    #2;

    // Reset for two cycles, then idle with sel = 0.
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, acc);
    step(1'b1, 1'b1, 8'hEF, 1'b1, 1'b1, acc);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // Routing.
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, acc);
    step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, acc);
    chk("y1_data_route", 32'(y1_data), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("y2_data_route", 32'(y2_data), 32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // Backpressure on Y1: second beat waits until the consumer is ready.
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1, acc);
    chk("bp_second_blocked", 32'(acc), 32'd0);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1, acc);
    chk("bp_second_taken", 32'(acc), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // Isolation: Y1 stalled and full, Y2 still accepts immediately.
    step(1'b1, 1'b0, 8'h44, 1'b0, 1'b1, acc);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, acc);
    chk("iso_accept", 32'(acc), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("iso_y2_data", 32'(y2_data), 32'h77);
    chk("iso_y1_data", 32'(y1_data), 32'h44);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // Mid-operation reset while Y2 holds a stalled beat.
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("rst_y2_valid", 32'(y2_valid), 32'd0);
    chk("rst_y1_count", 32'(y1_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // Counter wrap: 256 back-to-back beats into Y1.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, acc);
      chk("stream_accept", 32'(acc), 32'd1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("wrap_y1_count", 32'(y1_count), 32'd0);
    chk("wrap_y2_count", 32'(y2_count), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
    end
    rst_n = 1'b1;

    // Drain and confirm nothing was lost.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux1_2_stream.md
DEMUX1_2_STREAM -- requirements
Module: demux1_2_stream

Interface
REQ-001 Parameter DW, default 8, data width of input and both output channels.
REQ-002 Parameter CW, default 8, width of each per-channel beat counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_data  input  DW  upstream beat payload.
REQ-008 in_sel  input  1  route select; 0 = channel Y1, 1 = channel Y2; qualified by in_valid.
REQ-009 y1_valid  output  1  channel Y1 holds a beat.
REQ-010 y1_ready  input  1  Y1 consumer accepts the beat.
REQ-011 y1_data  output  DW  channel Y1 payload.
REQ-012 y2_valid, y2_ready, y2_data  output/input/output  1/1/DW  channel Y2, same meaning as Y1.
REQ-013 y1_count, y2_count  output  CW each  beats accepted into Y1/Y2 since reset.

Function
REQ-014 Transfer on any port occurs on the rising edge where its valid and ready are both 1.
REQ-015 Each channel has a one-entry holding register with a two-state FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-016 Channel FSM transitions:
- EMPTY -> FULL on an input transfer routed to it.
- FULL -> EMPTY on an output transfer with no input routed in that cycle.
- FULL -> FULL on simultaneous output and routed input; the register loads the new beat.
- Otherwise the state holds.
REQ-017 in_ready = (selected channel EMPTY) OR (selected channel FULL AND its yN_ready = 1); it is combinational from in_sel and yN_ready only, never from in_valid.
REQ-018 A beat goes only to the channel named by in_sel; the other channel's register, valid and counter are unaffected.
REQ-019 Latency: a beat accepted at edge N appears on yN_data with yN_valid = 1 after edge N, i.e. in cycle N+1.
REQ-020 Throughput: one beat per cycle sustained into a single channel when its consumer holds ready = 1.
REQ-021 While yN_valid = 1 and yN_ready = 0, yN_data and yN_valid hold stable.
REQ-022 in_data and in_sel are don't-care when in_valid = 0; no state changes.
REQ-023 A stall on one channel never blocks beats routed to the other channel.
REQ-024 yN_count increments by 1 on each input transfer routed to channel N, modulo 2^CW (2^CW-1 wraps to 0), with no saturation and no flag.
REQ-025 Beats routed to one channel leave in acceptance order; no reordering and no duplication.

Reset
REQ-026 While rst_n = 0 at a rising edge, both FSMs go to EMPTY, y1_valid = y2_valid = 0, and y1_count = y2_count = 0.
REQ-027 While rst_n = 0, in_ready = 0.
REQ-028 y1_data and y2_data reset to 0.
REQ-029 A reset asserted while a channel is FULL discards the held beat; no output transfer is reported for it.
REQ-030 Operation resumes on the first rising edge with rst_n = 1; a beat can be accepted in that same cycle.

Verification
REQ-031 Reset then idle: rst_n low 2 cycles -> valids 0, counts 0, in_ready 0 during reset; after reset, with in_sel = 0, in_ready = 1.
REQ-032 Routing: send 0xA5 with sel = 0, then 0x3C with sel = 1, both consumers ready -> y1_data = 0xA5 one cycle later and y2_data = 0x3C the cycle after; y1_count = 1, y2_count = 1.
REQ-033 Backpressure: y1_ready = 0, send 0x11 then 0x22 with sel = 0 -> 0x11 held stable on Y1 and in_ready = 0 for the second beat; raise y1_ready -> 0x11 drains, then 0x22; no loss.
REQ-034 Isolation: Y1 stalled and full; send 0x77 with sel = 1 -> accepted immediately and y2_data = 0x77 next cycle; Y1 is unchanged.
REQ-035 Wrap: CW = 8, 256 beats with sel = 0 -> y1_count returns to 0 and y2_count stays 0; streaming 1 beat/cycle with no bubbles.
REQ-036 Mid-operation reset: Y2 FULL holding 0x5A with y2_ready = 0; pulse rst_n low 1 cycle -> y2_valid = 0 and counts 0 after the edge; 0x5A is never delivered.
